// File: rtl/async_fifo_pkg.sv
// Shared helpers for the async FIFO family: Gray/binary conversion and
// defaults common to the read and write pointer blocks.
package async_fifo_pkg;

   localparam int SYNC_STAGES_DEFAULT = 2;

   // Widest pointer supported by the family (ADDRSIZE up to 10, plus wrap bit).
   localparam int PTR_W_MAX = 11;

   typedef logic [PTR_W_MAX-1:0] ptr_max_t;

   function automatic ptr_max_t bin2gray(input ptr_max_t bin);
      return (bin >> 1) ^ bin;
   endfunction

   // Zero-extended upper bits leave the XOR prefix unaffected, so callers
   // may pass narrower pointers widened to PTR_W_MAX.
   function automatic ptr_max_t gray2bin(input ptr_max_t gray);
      ptr_max_t bin;
      bin[PTR_W_MAX-1] = gray[PTR_W_MAX-1];
      for (int i = PTR_W_MAX-2; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction

endpackage

// File: rtl/sync_r2w.sv
// N-flop clock-domain-crossing synchronizer with asynchronous reset.
// Used as sync_r2w here and reusable as sync_w2r on the read side.
module sync_r2w
   import async_fifo_pkg::*;
#(
   parameter int WIDTH  = 5,
   parameter int STAGES = SYNC_STAGES_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage_q [STAGES];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < STAGES; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q[0] <= d;
         for (int i = 1; i < STAGES; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign q = stage_q[STAGES-1];

endmodule

// File: rtl/wptr_full_lvl.sv
// Write-side pointer block of the async FIFO: Gray write pointer, full,
// almost-full, pessimistic fill level and sticky overflow, all in wclk.
module wptr_full_lvl
   import async_fifo_pkg::*;
#(
   parameter int ADDRSIZE     = 4,
   parameter int SYNC_STAGES  = SYNC_STAGES_DEFAULT,
   parameter int AFULL_THRESH = 2**ADDRSIZE - 2
) (
   input  logic                wclk,
   input  logic                wrst,
   input  logic                wpush,
   input  logic                wovf_clr,
   input  logic [ADDRSIZE:0]   rptr_async,
   output logic                wen,
   output logic [ADDRSIZE-1:0] waddr,
   output logic [ADDRSIZE:0]   wptr,
   output logic                wfull,
   output logic                walmost_full,
   output logic [ADDRSIZE:0]   wlevel,
   output logic                wovf
);

   localparam int PW = ADDRSIZE + 1;

   if (ADDRSIZE < 2 || ADDRSIZE > 10) begin : g_bad_addrsize
      $error("wptr_full_lvl: ADDRSIZE must be in 2..10");
   end
   if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
      $error("wptr_full_lvl: SYNC_STAGES must be in 2..4");
   end
   if (AFULL_THRESH < 1 || AFULL_THRESH > 2**ADDRSIZE) begin : g_bad_thresh
      $error("wptr_full_lvl: AFULL_THRESH must be in 1..2**ADDRSIZE");
   end

   localparam logic [ADDRSIZE:0] AFULL_LVL = PW'(AFULL_THRESH);

   logic [ADDRSIZE:0] wbin;
   logic [ADDRSIZE:0] wbinnext;
   logic [ADDRSIZE:0] wgraynext;
   logic [ADDRSIZE:0] rptr_wclk;
   logic [ADDRSIZE:0] rbin_wclk;
   logic [ADDRSIZE:0] level_next;
   logic [ADDRSIZE:0] full_ptr;
   logic              full_next;
   logic              afull_next;

   sync_r2w #(
      .WIDTH  (PW),
      .STAGES (SYNC_STAGES)
   ) u_sync_r2w (
      .clk (wclk),
      .rst (wrst),
      .d   (rptr_async),
      .q   (rptr_wclk)
   );

   assign wen       = wpush & ~wfull;
   assign waddr     = wbin[ADDRSIZE-1:0];
   assign wbinnext  = wbin + PW'(wen);
   assign wgraynext = PW'(bin2gray(ptr_max_t'(wbinnext)));
   assign rbin_wclk = PW'(gray2bin(ptr_max_t'(rptr_wclk)));

   // Full when the next write pointer equals the read pointer with the two
   // top Gray bits inverted, i.e. exactly one depth ahead.
   assign full_ptr   = {~rptr_wclk[ADDRSIZE:ADDRSIZE-1], rptr_wclk[ADDRSIZE-2:0]};
   assign full_next  = (wgraynext == full_ptr);
   assign level_next = wbinnext - rbin_wclk;
   assign afull_next = (level_next >= AFULL_LVL);

   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         wbin         <= '0;
         wptr         <= '0;
         wfull        <= 1'b0;
         walmost_full <= 1'b0;
         wlevel       <= '0;
         wovf         <= 1'b0;
      end else begin
         wbin         <= wbinnext;
         wptr         <= wgraynext;
         wfull        <= full_next;
         walmost_full <= afull_next;
         wlevel       <= level_next;
         // A blocked push outranks a clear in the same cycle.
         if (wpush && wfull) begin
            wovf <= 1'b1;
         end else if (wovf_clr) begin
            wovf <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_wptr_full_lvl.sv
// Scoreboard bench for wptr_full_lvl at ADDRSIZE=2, SYNC_STAGES=2, AFULL_THRESH=3.
module tb_wptr_full_lvl;

   localparam int A = 2;

   logic         wclk = 1'b0;
   logic         wrst;
   logic         wpush;
   logic         wovf_clr;
   logic [A:0]   rptr_async;
   logic         wen;
   logic [A-1:0] waddr;
   logic [A:0]   wptr;
   logic         wfull;
   logic         walmost_full;
   logic [A:0]   wlevel;
   logic         wovf;

   wptr_full_lvl #(
      .ADDRSIZE     (A),
      .SYNC_STAGES  (2),
      .AFULL_THRESH (3)
   ) dut (
      .wclk         (wclk),
      .wrst         (wrst),
      .wpush        (wpush),
      .wovf_clr     (wovf_clr),
      .rptr_async   (rptr_async),
      .wen          (wen),
      .waddr        (waddr),
      .wptr         (wptr),
      .wfull        (wfull),
      .walmost_full (walmost_full),
      .wlevel       (wlevel),
      .wovf         (wovf)
   );

   always #5 wclk = ~wclk;

   typedef struct {
      int wptr;
      int waddr;
      int wfull;
      int afull;
      int level;
      int ovf;
   } exp_t;

   exp_t sbq[$];

   int total = 0;
   int bad   = 0;

   // 3-bit binary-to-Gray lookup, written out by hand
   int gt[8] = '{0, 1, 3, 2, 6, 7, 5, 4};

   int m_wbin, m_full, m_level, m_afull, m_ovf, rcnt;
   int m_rs[2];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // One wclk cycle: drive at negedge, check wen before the edge,
   // queue the model's prediction, compare #1 after the edge.
   task automatic step(input bit push, input bit clr, output int pre_waddr, output int pre_wen);
      exp_t e;
      int   nb, wen_m;
      wpush      = push;
      wovf_clr   = clr;
      rptr_async = 3'(gt[rcnt % 8]);
      #1;
      pre_waddr = int'(waddr);
      pre_wen   = int'(wen);
      wen_m = (push && m_full == 0) ? 1 : 0;
      check("wen", 32'(wen), wen_m);
      nb = (m_wbin + wen_m) % 8;
      if (push && m_full != 0) m_ovf = 1;
      else if (clr)            m_ovf = 0;
      m_level = (nb - m_rs[1] + 8) % 8;
      m_full  = (m_level == 4) ? 1 : 0;
      m_afull = (m_level >= 3) ? 1 : 0;
      m_wbin  = nb;
      m_rs[1] = m_rs[0];
      m_rs[0] = rcnt % 8;
      e.wptr  = gt[nb];
      e.waddr = nb % 4;
      e.wfull = m_full;
      e.afull = m_afull;
      e.level = m_level;
      e.ovf   = m_ovf;
      sbq.push_back(e);
      @(posedge wclk);
      #1;
      if (sbq.size() == 0) begin
         check("sbq_empty", 32'(sbq.size()), 1);
      end else begin
         e = sbq.pop_front();
         check("wptr",   32'(wptr),         e.wptr);
         check("waddr",  32'(waddr),        e.waddr);
         check("wfull",  32'(wfull),        e.wfull);
         check("afull",  32'(walmost_full), e.afull);
         check("wlevel", 32'(wlevel),       e.level);
         check("wovf",   32'(wovf),         e.ovf);
      end
      @(negedge wclk);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_wptr"},   32'(wptr),         0);
      check({tag, "_waddr"},  32'(waddr),        0);
      check({tag, "_wfull"},  32'(wfull),        0);
      check({tag, "_afull"},  32'(walmost_full), 0);
      check({tag, "_wlevel"}, 32'(wlevel),       0);
      check({tag, "_wovf"},   32'(wovf),         0);
      check({tag, "_wen"},    32'(wen),          0);
   endtask

   task automatic model_reset();
      m_wbin = 0; m_full = 0; m_level = 0; m_afull = 0; m_ovf = 0;
      m_rs[0] = 0; m_rs[1] = 0;
      rcnt = 0;
   endtask

   task automatic do_reset();
      wrst = 1'b1; wpush = 1'b0; wovf_clr = 1'b0; rptr_async = '0;
      model_reset();
      #1;
      check_zero("rst");
      @(posedge wclk);
      @(negedge wclk);
      wrst = 1'b0;
   endtask

   int wp_exp[4] = '{1, 3, 2, 6};
   int af_exp[4] = '{0, 0, 1, 1};
   int wf_exp[4] = '{0, 0, 0, 1};

   initial begin
      int pa, pw;
      logic [A:0] prev;

      // 1: four pushes into an empty FIFO
      do_reset();
      for (int i = 0; i < 4; i++) begin
         step(1, 0, pa, pw);
         check("s1_waddr_pre", 32'(pa), i);
         check("s1_wptr",  32'(wptr), wp_exp[i]);
         check("s1_level", 32'(wlevel), i + 1);
         check("s1_afull", 32'(walmost_full), af_exp[i]);
         check("s1_full",  32'(wfull), wf_exp[i]);
      end

      // 2: blocked pushes set the sticky overflow; clear drops it
      step(1, 0, pa, pw);
      check("s2_wen0", 32'(pw), 0);
      check("s2_wptr", 32'(wptr), 6);
      check("s2_ovf",  32'(wovf), 1);
      step(1, 1, pa, pw);
      check("s2_wen1", 32'(pw), 0);
      check("s2_ovf_setwins", 32'(wovf), 1);
      step(0, 1, pa, pw);
      check("s2_ovf_clr", 32'(wovf), 0);

      // 3: one read advance frees space three edges later
      rcnt = 1;
      step(0, 0, pa, pw);
      check("s3_full_e1", 32'(wfull), 1);
      step(0, 0, pa, pw);
      check("s3_full_e2", 32'(wfull), 1);
      check("s3_lvl_e2",  32'(wlevel), 4);
      step(0, 0, pa, pw);
      check("s3_full_e3", 32'(wfull), 0);
      check("s3_lvl_e3",  32'(wlevel), 3);

      // 5: refill, then push in the cycle where the synced read pointer moves
      step(1, 0, pa, pw);
      check("s5_refull", 32'(wfull), 1);
      rcnt = 2;
      step(0, 0, pa, pw);
      step(0, 0, pa, pw);
      step(1, 0, pa, pw);
      check("s5_blocked", 32'(pw), 0);
      check("s5_full0",   32'(wfull), 0);
      check("s5_ovf",     32'(wovf), 1);
      step(1, 0, pa, pw);
      check("s5_push_ok", 32'(pw), 1);
      check("s5_full1",   32'(wfull), 1);

      // 4: push/pop pairs across several pointer wraps
      do_reset();
      prev = wptr;
      for (int i = 0; i < 20; i++) begin
         for (int j = 0; j < 4; j++) begin
            if (j == 1) rcnt = rcnt + 1;
            step(j == 0, 0, pa, pw);
            check("s4_onebit", 32'($countones(prev ^ wptr) <= 1), 1);
            check("s4_lvl_le1", 32'(wlevel <= 3'd1), 1);
            check("s4_nofull", 32'(wfull), 0);
            prev = wptr;
         end
      end

      // 6: asynchronous reset in the middle of a burst
      do_reset();
      step(1, 0, pa, pw);
      step(1, 0, pa, pw);
      check("s6_lvl2", 32'(wlevel), 2);
      wpush = 1'b0;
      #2;
      wrst = 1'b1;
      rptr_async = '0;
      #1;
      check_zero("s6_async");
      model_reset();
      @(negedge wclk);
      wrst = 1'b0;
      step(1, 0, pa, pw);
      check("s6_first_addr", 32'(pa), 0);
      check("s6_lvl1", 32'(wlevel), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got=0 exp=1");
      $fatal(1, "timeout");
   end

endmodule
